// File: rtl/spi_txn_ctrl.sv
// rtl/spi_txn_ctrl.sv - SPI transaction sequencer: command byte, write payload, read payload.
// Optional watchdog enabled by defining SPI_TXN_TIMEOUT_EN.
module spi_txn_ctrl #(
  parameter int         P_LEN_WIDTH  = 4,
  parameter logic [7:0] P_DUMMY_BYTE = 8'h00,
  parameter int         P_TIMEOUT    = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [7:0]             i_txn_cmd,
  input  logic [P_LEN_WIDTH-1:0] i_txn_wr_len,
  input  logic [P_LEN_WIDTH-1:0] i_txn_rd_len,
  input  logic                   i_txn_valid,
  output logic                   o_txn_ready,
  input  logic [7:0]             i_wdata,
  input  logic                   i_wdata_valid,
  output logic                   o_wdata_ready,
  output logic [7:0]             o_rdata,
  output logic                   o_rdata_valid,
  output logic [7:0]             o_drv_wdata,
  output logic                   o_drv_wvalid,
  input  logic                   i_drv_wready,
  input  logic [7:0]             i_drv_rdata,
  input  logic                   i_drv_rvalid,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

  localparam int CW = P_LEN_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WR, S_RD, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [7:0]    cmd_q;
  logic [CW-1:0] wr_len_q, rd_len_q;
  logic [CW-1:0] wr_cnt, rd_iss_cnt, rd_rcv_cnt;
  logic          accept, drv_hs, rd_fwd, timeout;

  assign accept        = i_txn_valid && (state == S_IDLE);
  assign drv_hs        = o_drv_wvalid && i_drv_wready;
  assign rd_fwd        = (state == S_RD) && i_drv_rvalid;
  assign o_txn_ready   = (state == S_IDLE);
  assign o_busy        = (state != S_IDLE);
  assign o_done        = (state == S_DONE);
  assign o_rdata_valid = rd_fwd;
  assign o_rdata       = rd_fwd ? i_drv_rdata : 8'h00;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    o_drv_wdata   = 8'h00;
    o_drv_wvalid  = 1'b0;
    o_wdata_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_CMD;
      end
      S_CMD: begin
        o_drv_wdata  = cmd_q;
        o_drv_wvalid = 1'b1;
        if (i_drv_wready) begin
          if (wr_len_q != '0)      state_nxt = S_WR;
          else if (rd_len_q != '0) state_nxt = S_RD;
          else                     state_nxt = S_DONE;
        end
      end
      S_WR: begin
        o_drv_wdata   = i_wdata;
        o_drv_wvalid  = i_wdata_valid;
        o_wdata_ready = i_drv_wready;
        if (i_wdata_valid && i_drv_wready && (wr_cnt + CW'(1) == wr_len_q)) begin
          state_nxt = (rd_len_q != '0) ? S_RD : S_DONE;
        end
      end
      S_RD: begin
        // Dummy bytes stop once every read byte has been clocked out; we then wait for the data.
        o_drv_wdata  = P_DUMMY_BYTE;
        o_drv_wvalid = (rd_iss_cnt < rd_len_q);
        if (rd_fwd && (rd_rcv_cnt + CW'(1) == rd_len_q)) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (timeout) state_nxt = S_DONE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cmd_q      <= 8'h00;
      wr_len_q   <= '0;
      rd_len_q   <= '0;
      wr_cnt     <= '0;
      rd_iss_cnt <= '0;
      rd_rcv_cnt <= '0;
    end else begin
      if (accept) begin
        cmd_q      <= i_txn_cmd;
        wr_len_q   <= {1'b0, i_txn_wr_len};
        rd_len_q   <= {1'b0, i_txn_rd_len};
        wr_cnt     <= '0;
        rd_iss_cnt <= '0;
        rd_rcv_cnt <= '0;
      end
      if ((state == S_WR) && drv_hs) wr_cnt <= wr_cnt + CW'(1);
      if ((state == S_RD) && drv_hs) rd_iss_cnt <= rd_iss_cnt + CW'(1);
      if (rd_fwd) rd_rcv_cnt <= rd_rcv_cnt + CW'(1);
    end
  end

`ifdef SPI_TXN_TIMEOUT_EN
  localparam int TW = $clog2(P_TIMEOUT + 1);

  logic [TW-1:0] wd_cnt;
  logic          err_q;
  logic          active;

  assign active  = (state == S_CMD) || (state == S_WR) || (state == S_RD);
  // Limit is hit on the cycle that would make the count reach P_TIMEOUT; DONE follows at that edge.
  assign timeout = active && !drv_hs && !rd_fwd && (wd_cnt == TW'(P_TIMEOUT - 1));
  assign o_err   = (state == S_DONE) && err_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept || drv_hs || rd_fwd || !active) wd_cnt <= '0;
      else                                       wd_cnt <= wd_cnt + TW'(1);
      err_q <= timeout;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (P_TIMEOUT > 0);
  assign timeout        = 1'b0;
  assign o_err          = 1'b0;
`endif

endmodule

// File: doc/spi_txn_ctrl.md
SPI_TXN_CTRL -- requirements
Module: spi_txn_ctrl

Interface
REQ-001 SHALL have parameter P_LEN_WIDTH, default 4, width of the write and read byte-count fields.
REQ-002 SHALL have parameter P_DUMMY_BYTE, default 8'h00, the byte sent on MOSI during read phase.
REQ-003 SHALL have parameter P_TIMEOUT, default 1024, the watchdog limit in i_clk cycles (used only under REQ-027).
REQ-004 SHALL have port i_clk  in  1  clock.
REQ-005 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_txn_cmd  in  8  command/opcode byte.
REQ-007 SHALL have ports i_txn_wr_len, i_txn_rd_len  in  P_LEN_WIDTH  payload byte counts, 0 meaning phase skipped.
REQ-008 SHALL have ports i_txn_valid  in  1 / o_txn_ready  out  1  transaction request handshake.
REQ-009 SHALL have ports i_wdata  in  8 / i_wdata_valid  in  1 / o_wdata_ready  out  1  write payload stream.
REQ-010 SHALL have ports o_rdata  out  8 / o_rdata_valid  out  1  read payload stream, no backpressure.
REQ-011 SHALL have ports o_drv_wdata  out  8 / o_drv_wvalid  out  1 / i_drv_wready  in  1  byte request to the SPI byte driver.
REQ-012 SHALL have ports i_drv_rdata  in  8 / i_drv_rvalid  in  1  byte received from the driver.
REQ-013 SHALL have ports o_busy  out  1, o_done  out  1 (pulse), o_err  out  1 (pulse).

Function
REQ-014 SHALL implement FSM states IDLE, CMD, WR, RD, DONE.
REQ-015 o_txn_ready SHALL be 1 only in IDLE; on i_txn_valid & o_txn_ready, latch cmd/wr_len/rd_len and move to CMD.
REQ-016 CMD: o_drv_wdata=latched cmd, o_drv_wvalid=1; on o_drv_wvalid & i_drv_wready go to WR if wr_len!=0, else RD if rd_len!=0, else DONE.
REQ-017 A byte SHALL transfer to the driver only in a cycle where o_drv_wvalid & i_drv_wready are both 1; exactly one transfer per handshake cycle.
REQ-018 WR: combinational pass-through o_drv_wdata=i_wdata, o_drv_wvalid=i_wdata_valid, o_wdata_ready=i_drv_wready; o_wdata_ready=0 in all other states.
REQ-019 WR: count accepted bytes; after the wr_len-th handshake go to RD if rd_len!=0, else DONE.
REQ-020 RD: issue P_DUMMY_BYTE per handshake until rd_len bytes issued, then hold o_drv_wvalid=0.
REQ-021 i_drv_rvalid SHALL be forwarded to o_rdata/o_rdata_valid only in RD; same-cycle, o_rdata=i_drv_rdata; rvalid in IDLE/CMD/WR/DONE is dropped.
REQ-022 RD SHALL go to DONE in the cycle the rd_len-th forwarded rvalid arrives.
REQ-023 DONE: o_done=1 for one cycle, then IDLE; o_busy=1 in every state except IDLE.
REQ-024 Counters SHALL be P_LEN_WIDTH+1 bits wide; max length 2^P_LEN_WIDTH-1 (15) SHALL complete without wrap.
REQ-025 New i_txn_valid while busy SHALL be ignored (not accepted, not queued).

Reset
REQ-026 On i_rst: state IDLE, counters 0, latched fields 0, o_drv_wvalid=0, o_rdata=0, o_rdata_valid=0, o_done=0, o_err=0, o_busy=0, o_txn_ready=1; reset mid-transaction abandons it with no o_done.

Configuration
REQ-027 Macro SPI_TXN_TIMEOUT_EN: when defined, a watchdog counter clears on entering CMD, on every driver handshake and every forwarded rvalid, increments otherwise while busy; reaching P_TIMEOUT forces DONE with o_err=1 and o_done=1 in that DONE cycle; when undefined, no counter exists, o_err tied 0, FSM waits indefinitely.

Verification
REQ-028 cmd=8'h9F, wr=0, rd=3, driver returns EF,40,18 -> drv bytes 9F,00,00,00; o_rdata_valid x3 with EF,40,18; one o_done.
REQ-029 cmd=8'h02, wr=4 data 11,22,33,44, rd=0 -> drv bytes 02,11,22,33,44; no o_rdata_valid; o_done after 5th handshake.
REQ-030 cmd=8'h06, wr=0, rd=0 -> single drv byte 06, CMD->DONE->IDLE, o_txn_ready back 1 two cycles after the handshake.
REQ-031 wr=2 with i_wdata_valid gapped 5 cycles between bytes, and i_txn_valid asserted mid-transaction -> no extra drv bytes, second request not accepted until IDLE.
REQ-032 i_rst pulsed during RD byte 2 of 3 -> all outputs at reset values next cycle, no o_done; following transaction completes normally.
REQ-033 With SPI_TXN_TIMEOUT_EN, P_TIMEOUT=16, i_drv_wready held 0 -> o_err and o_done pulse together 16 cycles after CMD entry; without macro, FSM stays in CMD.
